booth_mult_arbiter: RTL
=======================

Name: booth_mult_arbiter

Overview:
Shares one Booth multiplier datapath (6-bit signed operands, 12-bit product, start/ready handshake) among NREQ requesters. The block arbitrates round-robin and latches the winner's operands. It drives the multiplier's start line, waits for the multiplier to finish, and returns the product with a one-cycle done strobe to the winner. A timeout watchdog recovers from a multiplier that never responds.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 6, operand width; product is 2*WIDTH
TIMEOUT, 63, max cycles spent in WAIT_ACC or WAIT_DONE before abort

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req  input  NREQ  per-requester request level
a_in  input  NREQ*WIDTH  multiplicands, requester i at [i*WIDTH +: WIDTH]
b_in  input  NREQ*WIDTH  multipliers, same packing
gnt  output  NREQ  one-hot grant, held from ISSUE through RESP
done  output  NREQ  one-hot, one-cycle completion strobe
err  output  1  one-cycle strobe alongside done when the op timed out
result  output  2*WIDTH  product of the last completed op, held until next done
busy  output  1  high in every state except IDLE
mul_start  output  1  to multiplier start
mul_multiplicand  output  WIDTH  latched operand a
mul_multiplier  output  WIDTH  latched operand b
mul_ready  input  1  from multiplier: high when idle/finished, low while computing
mul_out  input  2*WIDTH  multiplier product

Behaviour:
- Reset (rst=0, async): state=IDLE; gnt, done, err, busy, mul_start, result, mul_multiplicand and mul_multiplier are all 0; round-robin pointer = NREQ-1, so req[0] has top priority first. Mid-operation reset aborts silently with no done.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_ACC, WAIT_DONE, RESP.
- IDLE: if any req bit is set, pick the first set bit searching from ptr+1 upward, with wrap. Set gnt to that one-hot bit and latch its a/b into the mul_* operand registers. Go to ISSUE. No req: stay.
- ISSUE: mul_start=1. Go to WAIT_ACC.
- WAIT_ACC: mul_start stays 1. On mul_ready=0 (multiplier accepted), go to WAIT_DONE.
- WAIT_DONE: mul_start stays 1. On mul_ready=1, capture mul_out into result and go to RESP.
- RESP: mul_start=0. Pulse done[winner] for exactly this cycle; gnt still asserted. Set ptr=winner. Next state IDLE, with gnt cleared.
- Earliest case: req sampled at edge k gives gnt and operands at k+1, mul_start at k+2, and done at WAIT_DONE exit +1.
- The arbiter re-arbitrates only in IDLE, so at least one IDLE cycle separates consecutive ops.
- Timeout: a cycle counter clears on entry to WAIT_ACC and counts in WAIT_ACC and WAIT_DONE. When it reaches TIMEOUT, go to RESP with err=1 and result unchanged. done still pulses so the requester is released.
- Requester contract: hold req until done. If req drops mid-op, the op still completes and done still pulses. If req is still high after done, it re-competes at lowest priority relative to the others.
- Operands are latched at grant. Changes on a_in/b_in after grant are ignored.
- result is the raw 2*WIDTH two's-complement value from the multiplier. No sign or width manipulation.
- Simultaneous requests are never lost: the losers stay pending and are served in rotation order.

Test Plan:
- Reset then single req[0], a=6'b010001, b=6'b010111 (17*23) -> gnt=0001; mul_start held until ready rises; done=0001 one cycle; result=12'h187; err=0; busy low afterwards.
- All four req high: r0 -31*11, r1 20*-29, r2 -12*-13, r3 0*18. Grants go in order 0,1,2,3. Results are 12'hEAB, 12'hDBC, 12'h09C, 12'h000 on the matching done bits.
- Starvation check: req[1] held permanently, req[2] asserted after the first grant. Grant sequence is 1,2,1,2. req[2] completes before req[1]'s second op.
- Operand change after grant: a_in for r0 changes from 5 to 7 one cycle after gnt, b=3 -> result=12'h00F.
- Multiplier model with mul_ready stuck high -> exit after TIMEOUT cycles in WAIT_ACC; done and err pulse together; result keeps its previous value; next request is served normally.
- rst driven low asynchronously during WAIT_DONE -> all outputs 0 immediately with no done pulse. After release, a new req[3] gets the grant first, since ptr=NREQ-1 wraps to 0, 1, 2, 3 and 3 is the only request pending.

Source files
------------

// File: rtl/booth_mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_arbiter_if
// Brief    : Requester-side and multiplier-side bus of booth_mult_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface booth_mult_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 6
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic [2*WIDTH-1:0]    result;
    logic                  busy;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_multiplicand;
    logic [WIDTH-1:0]      mul_multiplier;
    logic                  mul_ready;
    logic [2*WIDTH-1:0]    mul_out;

    // Arbiter view.
    modport slave (
        input  req, a_in, b_in, mul_ready, mul_out,
        output gnt, done, err, result, busy,
               mul_start, mul_multiplicand, mul_multiplier
    );

    // Environment view: requesters plus the multiplier.
    modport master (
        output req, a_in, b_in, mul_ready, mul_out,
        input  gnt, done, err, result, busy,
               mul_start, mul_multiplicand, mul_multiplier
    );
endinterface
`default_nettype wire

// File: rtl/booth_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_arbiter
// Brief    : Round-robin sharing of one Booth multiplier with timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module booth_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 6,
    parameter int TIMEOUT = 63
) (
    input  wire logic           clk,
    input  wire logic           rst,
    booth_mult_arbiter_if.slave bus
);
    localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ISSUE     = 3'd1;
    localparam logic [2:0] c_WAIT_ACC  = 3'd2;
    localparam logic [2:0] c_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_RESP      = 3'd4;

    logic [2:0]         r_state;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_done;
    logic               r_err;
    logic               r_busy;
    logic               r_start;
    logic [2*WIDTH-1:0] r_result;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_PW-1:0]    r_ptr;
    logic [c_PW-1:0]    r_win;
    logic [c_CW-1:0]    r_cnt;

    logic               w_any;
    logic [c_PW-1:0]    w_idx;
    logic [c_PW:0]      w_sum;
    logic               w_tmo;

    // Scan offsets from farthest to nearest so the request closest after r_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_sum = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_sum = {1'b0, r_ptr} + (c_PW + 1)'(k);
            if (w_sum >= (c_PW + 1)'(NREQ)) begin
                w_sum = w_sum - (c_PW + 1)'(NREQ);
            end
            if (bus.req[w_sum[c_PW-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_sum[c_PW-1:0];
            end
        end
    end

    assign w_tmo = (r_cnt >= c_CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_IDLE;
            r_gnt    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_start  <= 1'b0;
            r_result <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_ptr    <= c_PW'(NREQ - 1);
            r_win    <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_state  <= c_ISSUE;
                        r_gnt    <= NREQ'(1) << w_idx;
                        r_win    <= w_idx;
                        r_mcand  <= bus.a_in[w_idx*WIDTH +: WIDTH];
                        r_mplier <= bus.b_in[w_idx*WIDTH +: WIDTH];
                        r_busy   <= 1'b1;
                    end
                end
                c_ISSUE: begin
                    r_start <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= c_WAIT_ACC;
                end
                c_WAIT_ACC: begin
                    if (!bus.mul_ready) begin
                        r_state <= c_WAIT_DONE;
                        r_cnt   <= r_cnt + 1'b1;
                    end else if (w_tmo) begin
                        r_state <= c_RESP;
                        r_start <= 1'b0;
                        r_done  <= r_gnt;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_WAIT_DONE: begin
                    if (bus.mul_ready) begin
                        r_state  <= c_RESP;
                        r_start  <= 1'b0;
                        r_done   <= r_gnt;
                        r_result <= bus.mul_out;
                    end else if (w_tmo) begin
                        // Abort keeps the previous product visible.
                        r_state <= c_RESP;
                        r_start <= 1'b0;
                        r_done  <= r_gnt;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= r_win;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt              = r_gnt;
    assign bus.done             = r_done;
    assign bus.err              = r_err;
    assign bus.result           = r_result;
    assign bus.busy             = r_busy;
    assign bus.mul_start        = r_start;
    assign bus.mul_multiplicand = r_mcand;
    assign bus.mul_multiplier   = r_mplier;
endmodule
`default_nettype wire
